// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: opcodes, FSM encoding, sizing helper.
package calc_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand request / result bundle between operand capture and the result register.
interface serial_addsub_if #(parameter int WIDTH = 8);

    logic             start;
    logic             sub_mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic             zero;

    modport master (
        output start, sub_mode, x, y,
        input  busy, done, result, carry, overflow, negative, zero
    );

    modport slave (
        input  start, sub_mode, x, y,
        output busy, done, result, carry, overflow, negative, zero
    );

endinterface

// File: rtl/addsub_slice.sv
// DIGIT-bit adder slice with carry-in; reports carry-out and carry into its MSB.
// Latency: combinational.
// Backpressure: none.
module addsub_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum  = full[DIGIT-1:0];
    assign cout = full[DIGIT];
    // The carry entering the top bit is recovered from that bit's sum.
    assign cmsb = a[DIGIT-1] ^ b[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, LSB first, DIGIT bits per clock through a shared slice.
// Latency: done pulses N+1 cycles after the start edge (N = WIDTH/DIGIT).
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE.
module serial_addsub
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             c;
    logic             c_msb;
    logic             sub_q;
    logic [CW-1:0]    cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             neg_q;
    logic             zero_q;

    logic [DIGIT-1:0]       dsum;
    logic                   dcout;
    logic                   dcmsb;
    logic [WIDTH+DIGIT-1:0] r_cat;

    addsub_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (c),
        .sum  (dsum),
        .cout (dcout),
        .cmsb (dcmsb)
    );

    // New digit enters at the top, so after N digits r_sh holds the full result.
    assign r_cat = {dsum, r_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            c        <= 1'b0;
            c_msb    <= 1'b0;
            sub_q    <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.x;
                        b_sh   <= (bus.sub_mode == OP_SUB) ? ~bus.y : bus.y;
                        c      <= bus.sub_mode;
                        sub_q  <= bus.sub_mode;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt == LAST) begin
                        result_q <= r_sh;
                        carry_q  <= c ^ sub_q;
                        ovf_q    <= c_msb ^ c;
                        neg_q    <= r_sh[WIDTH-1];
                        zero_q   <= (r_sh == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        r_sh  <= r_cat[WIDTH+DIGIT-1:DIGIT];
                        a_sh  <= a_sh >> DIGIT;
                        b_sh  <= b_sh >> DIGIT;
                        c     <= dcout;
                        c_msb <= dcmsb;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.negative = neg_q;
    assign bus.zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub in three WIDTH/DIGIT configurations.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_if #(.WIDTH(8))  b0 ();
    serial_addsub_if #(.WIDTH(8))  b1 ();
    serial_addsub_if #(.WIDTH(16)) b2 ();

    serial_addsub #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    serial_addsub #(.WIDTH(8),  .DIGIT(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
    serial_addsub #(.WIDTH(16), .DIGIT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input int w, input longint x, input longint y,
                                   input logic sub, input int at);
        exp_t   e;
        longint m;
        longint r;
        longint sx;
        longint sy;
        longint sr;
        m  = (64'd1 << w) - 1;
        r  = sub ? (x - y) : (x + y);
        e.res = 16'(r & m);
        e.c   = sub ? (x < y) : (r > m);
        sx = (x >> (w - 1)) & 1;
        sy = (y >> (w - 1)) & 1;
        sr = ((r & m) >> (w - 1)) & 1;
        e.v   = sub ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
        e.n   = (sr != 0);
        e.z   = ((r & m) == 0);
        e.at  = at;
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic [15:0] res,
                         input logic c, input logic v, input logic n, input logic z);
        chk({tag, ".latency"},  cyc, e.at);
        chk({tag, ".result"},   res, e.res);
        chk({tag, ".carry"},    c,   e.c);
        chk({tag, ".overflow"}, v,   e.v);
        chk({tag, ".negative"}, n,   e.n);
        chk({tag, ".zero"},     z,   e.z);
    endtask

    always @(negedge clk) begin
        if (b0.done) begin
            if (q0.size() == 0) chk("u0.spurious_done", b0.done, 0);
            else score("u0", q0.pop_front(), 16'(b0.result), b0.carry, b0.overflow, b0.negative, b0.zero);
        end
    end

    always @(negedge clk) begin
        if (b1.done) begin
            if (q1.size() == 0) chk("u1.spurious_done", b1.done, 0);
            else score("u1", q1.pop_front(), 16'(b1.result), b1.carry, b1.overflow, b1.negative, b1.zero);
        end
    end

    always @(negedge clk) begin
        if (b2.done) begin
            if (q2.size() == 0) chk("u2.spurious_done", b2.done, 0);
            else score("u2", q2.pop_front(), b2.result, b2.carry, b2.overflow, b2.negative, b2.zero);
        end
    end

    function automatic int qsize(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Called at a negedge: drives start for exactly one edge and queues the expectation.
    task automatic op(input int u, input int x, input int y, input logic sub);
        int at;
        case (u)
            0: begin
                at = cyc + 8 + 2;
                b0.x = x[7:0]; b0.y = y[7:0]; b0.sub_mode = sub; b0.start = 1'b1;
                q0.push_back(model(8, longint'(x[7:0]), longint'(y[7:0]), sub, at));
            end
            1: begin
                at = cyc + 2 + 2;
                b1.x = x[7:0]; b1.y = y[7:0]; b1.sub_mode = sub; b1.start = 1'b1;
                q1.push_back(model(8, longint'(x[7:0]), longint'(y[7:0]), sub, at));
            end
            default: begin
                at = cyc + 8 + 2;
                b2.x = x[15:0]; b2.y = y[15:0]; b2.sub_mode = sub; b2.start = 1'b1;
                q2.push_back(model(16, longint'(x[15:0]), longint'(y[15:0]), sub, at));
            end
        endcase
        @(negedge clk);
        b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
        // Operands wander after the start edge; the DUT must not care.
        b0.x = 8'($urandom);  b0.y = 8'($urandom);  b0.sub_mode = 1'($urandom);
        b1.x = 8'($urandom);  b1.y = 8'($urandom);  b1.sub_mode = 1'($urandom);
        b2.x = 16'($urandom); b2.y = 16'($urandom); b2.sub_mode = 1'($urandom);
    endtask

    task automatic wait_idle(input int u);
        for (int i = 0; i < 60; i++) begin
            if (qsize(u) == 0) break;
            @(negedge clk);
        end
        chk($sformatf("u%0d.timeout", u), qsize(u), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b0.start = 1'b0; b0.sub_mode = 1'b0; b0.x = '0; b0.y = '0;
        b1.start = 1'b0; b1.sub_mode = 1'b0; b1.x = '0; b1.y = '0;
        b2.start = 1'b0; b2.sub_mode = 1'b0; b2.x = '0; b2.y = '0;
        repeat (3) @(negedge clk);

        chk("rst.busy",     b0.busy, 0);
        chk("rst.done",     b0.done, 0);
        chk("rst.result",   b0.result, 0);
        chk("rst.carry",    b0.carry, 0);
        chk("rst.overflow", b0.overflow, 0);
        chk("rst.negative", b0.negative, 0);
        chk("rst.zero",     b0.zero, 1);
        chk("rst.u2.zero",  b2.zero, 1);
        rst = 1'b0;
        @(negedge clk);

        op(0, 5, 3, 1'b0);        wait_idle(0);
        op(0, 3, 5, 1'b1);        wait_idle(0);
        op(0, 'h80, 1, 1'b1);     wait_idle(0);
        op(0, 'h7F, 1, 1'b0);     wait_idle(0);
        op(0, 'hFF, 1, 1'b0);     wait_idle(0);

        // Second start three cycles into RUN must be dropped.
        op(0, 'h21, 'h13, 1'b0);
        repeat (2) @(negedge clk);
        b0.x = 8'hAA; b0.y = 8'h55; b0.sub_mode = 1'b1; b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        chk("u0.busy_ignore", b0.busy, 1);
        for (int i = 0; i < 20; i++) begin
            if (b0.done) break;
            chk("u0.busy_run", b0.busy, 1);
            @(negedge clk);
        end
        chk("u0.busy_in_done", b0.busy, 0);
        // Back-to-back: start during the done cycle, no IDLE in between.
        op(0, 'h40, 'h41, 1'b1);
        chk("u0.b2b_busy", b0.busy, 1);
        chk("u0.hold_result", b0.result, 8'h34);
        wait_idle(0);

        // Reset four cycles into RUN aborts without a done pulse.
        op(0, 'h12, 'h34, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy",   b0.busy, 0);
        chk("abort.result", b0.result, 0);
        chk("abort.zero",   b0.zero, 1);
        chk("abort.done",   b0.done, 0);
        q0.delete(q0.size() - 1);
        repeat (15) @(negedge clk);
        op(0, 'h64, 'h9C, 1'b1);  wait_idle(0);

        op(1, 'h9A, 'h66, 1'b0);  wait_idle(1);
        op(2, 1000, 1001, 1'b1);  wait_idle(2);

        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 6; i++) begin
                op(u, int'($urandom), int'($urandom), 1'($urandom_range(0, 1)));
                wait_idle(u);
            end
        end

        repeat (5) @(negedge clk);
        chk("u0.pending", q0.size(), 0);
        chk("u1.pending", q1.size(), 0);
        chk("u2.pending", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised, multi-cycle add/subtract unit for the calculator datapath. It supersedes the fixed 4-bit combinational subtractor.
- Operands are latched on a start pulse and processed DIGIT bits per clock, LSB first, through a small shared adder slice.
- Result and status flags are registered and presented with a done pulse.
- Sits between operand/keypad capture and the display/result register.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
DIGIT, 1, bits processed per clock; WIDTH % DIGIT must be 0 (elaboration-time check)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only when not busy
sub_mode  input  1  0 = x+y, 1 = x-y; sampled with start
x  input  WIDTH  operand A, sampled with start
y  input  WIDTH  operand B, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result/flags become valid
result  output  WIDTH  x+y or x-y modulo 2^WIDTH
carry  output  1  add: carry-out; sub: borrow (1 when x<y unsigned)
overflow  output  1  signed two's-complement overflow
negative  output  1  result[WIDTH-1]
zero  output  1  result == 0

Behaviour:
- Constant N = WIDTH/DIGIT cycles per operation.
- Single clock domain.
- Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, result=0, carry=0, overflow=0, negative=0, zero=1. FSM goes to IDLE; internal shift registers and counter are cleared.
- States:
  - IDLE: waiting for start.
  - RUN: processing digits.
  - DONE: one cycle, done=1.
- IDLE -> RUN on start=1:
  - Latch x into a_sh.
  - Latch y into b_sh, or ~y when sub_mode=1.
  - Set carry register c = sub_mode; cnt = 0; busy=1 from the next cycle.
- RUN, each cycle:
  - {c, digit} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + c.
  - Shift digit into the MSB end of r_sh; shift a_sh and b_sh right by DIGIT.
  - cnt++.
  - Record the carry into the top bit position; this is needed for overflow.
- RUN -> DONE when cnt == N-1 completes. On that transition, register:
  - result = r_sh.
  - carry = c_out XOR sub_mode_latched.
  - overflow = carry into MSB XOR carry out of MSB.
  - negative and zero from the final result.
- DONE: done=1 and busy=0 for exactly one cycle.
  - With start=1 in DONE, go directly to RUN, latching new operands (back-to-back).
  - Otherwise return to IDLE.
- Latency: start sampled at edge k gives done=1 in the cycle following edge k+N+1, i.e. N+1 cycles after the start edge. Throughput is one operation per N+1 cycles.
- Outputs result/carry/overflow/negative/zero update only on the RUN->DONE transition. They hold their value until the next completion or reset, and are not disturbed during a subsequent RUN.
- start while busy=1 (RUN) is ignored; there is no queueing.
- Operand changes after the start edge have no effect.
- rst asserted mid-RUN aborts the operation: all outputs return to reset values next cycle and no done is issued.
- Arithmetic wraps modulo 2^WIDTH. Subtraction is x + ~y + 1.

Decomposition:
- Shared package calc_pkg holds:
  - Opcode constants OP_ADD=1'b0, OP_SUB=1'b1.
  - FSM state encoding ST_IDLE, ST_RUN, ST_DONE (2-bit).
  - A function clog2 used to size cnt.
- One natural sub-module, addsub_slice: combinational DIGIT-bit adder with carry-in. Outputs are the sum, carry-out, and carry into the slice MSB, which is used for overflow on the last digit.
- Top-level serial_addsub holds the FSM, shift registers, counter and flag registers.

Test Plan:
- WIDTH=8, DIGIT=1: start with x=5, y=3, sub_mode=0 -> done exactly 9 cycles after start edge; result=8, carry=0, overflow=0, zero=0, negative=0.
- WIDTH=8, DIGIT=1: x=3, y=5, sub_mode=1 -> result=0xFE, carry(borrow)=1, negative=1, overflow=0. Then x=0x80, y=1, sub_mode=1 -> result=0x7F, overflow=1, carry=0.
- WIDTH=8, DIGIT=1: x=0x7F, y=1, add -> result=0x80, overflow=1, negative=1. Then x=0xFF, y=1, add -> result=0, carry=1, zero=1, overflow=0.
- Pulse start again 3 cycles into RUN with different operands -> ignored: single done with the original result, busy stays high throughout. Then start held high in DONE -> new operation begins with no IDLE cycle.
- Assert rst 4 cycles into RUN -> next cycle busy=0, result=0, zero=1; no done pulse ever follows. A fresh start afterwards completes normally.
- WIDTH=8, DIGIT=4: x=0x9A, y=0x66, add -> done 3 cycles after start edge, result=0x00, carry=1, zero=1. WIDTH=16, DIGIT=2: x=1000, y=1001, sub -> result=0xFFFF, borrow=1, after 9 cycles.
